// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Holds one instruction from EX, formats load
//   data returned by the data SRAM and forwards the result to WB and to ID bypass.
// Latency: one cycle (instruction is presented to WB the cycle after it enters).
// Backpressure: mem_allow_in drops while WB stalls a valid held instruction;
//   load data is latched on entry, so a stall of any length keeps the result stable.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   exe_to_mem_valid/_bus - instruction from EX {res_from_mem, load_op, gr_we, dest, alu_result, pc}
//   mem_allow_in          - MEM accepts a new instruction this cycle
//   data_sram_rdata       - load data, valid on the first cycle an instruction sits in MEM
//   wb_allow_in           - WB accepts an instruction this cycle
//   mem_to_wb_valid/_bus  - instruction to WB {gr_we, dest, final_result, pc}
//   mem_fwd_*             - bypass / load-use information for ID
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_to_mem_valid,
  input  logic [73:0] exe_to_mem_bus,
  output logic        mem_allow_in,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allow_in,
  output logic        mem_to_wb_valid,
  output logic [69:0] mem_to_wb_bus,
  output logic        mem_fwd_we,
  output logic [4:0]  mem_fwd_dest,
  output logic [31:0] mem_fwd_data,
  output logic        mem_fwd_is_load
);

  logic        mem_valid_q,  mem_valid_d;
  logic [73:0] payload_q,    payload_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic        hold_valid_q, hold_valid_d;

  logic        mem_ready_go;
  logic        load_new;

  // payload fields
  logic        res_from_mem;
  logic [2:0]  load_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  logic [31:0] eff_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign mem_ready_go = 1'b1;
  assign mem_allow_in = !mem_valid_q || (mem_ready_go && wb_allow_in);
  assign load_new     = mem_allow_in && exe_to_mem_valid;

  assign {res_from_mem, load_op, gr_we, dest, alu_result, pc} = payload_q;

  // Next-state logic
  always_comb begin
    mem_valid_d  = mem_valid_q;
    payload_d    = payload_q;
    rdata_hold_d = rdata_hold_q;
    hold_valid_d = hold_valid_q;

    if (mem_allow_in) begin
      mem_valid_d = exe_to_mem_valid;
    end
    if (load_new) begin
      payload_d = exe_to_mem_bus;
    end

    // SRAM data is only guaranteed on the first occupied cycle; latch it then.
    if (mem_valid_q && !hold_valid_q) begin
      rdata_hold_d = data_sram_rdata;
      hold_valid_d = 1'b1;
    end
    // A fresh instruction needs its own first-cycle data; an empty stage holds nothing.
    if (load_new || !mem_valid_d) begin
      hold_valid_d = 1'b0;
    end

    if (reset) begin
      mem_valid_d  = 1'b0;
      payload_d    = '0;
      rdata_hold_d = '0;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_valid_q  <= mem_valid_d;
    payload_q    <= payload_d;
    rdata_hold_q <= rdata_hold_d;
    hold_valid_q <= hold_valid_d;
  end

  // Load data formatting
  assign eff_rdata = hold_valid_q ? rdata_hold_q : data_sram_rdata;

  always_comb begin
    byte_sel = eff_rdata[7:0];
    case (alu_result[1:0])
      2'b00:   byte_sel = eff_rdata[7:0];
      2'b01:   byte_sel = eff_rdata[15:8];
      2'b10:   byte_sel = eff_rdata[23:16];
      default: byte_sel = eff_rdata[31:24];
    endcase
  end

  // alu_result[0] is deliberately ignored for halfwords; misalignment is not trapped here.
  assign half_sel = alu_result[1] ? eff_rdata[31:16] : eff_rdata[15:0];

  always_comb begin
    load_result = eff_rdata;
    case (load_op)
      3'b001:  load_result = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_result = {{16{half_sel[15]}}, half_sel};
      3'b011:  load_result = {24'b0, byte_sel};
      3'b100:  load_result = {16'b0, half_sel};
      default: load_result = eff_rdata;
    endcase
  end

  assign final_result = res_from_mem ? load_result : alu_result;

  // Outputs
  assign mem_to_wb_valid = mem_valid_q && mem_ready_go;
  assign mem_to_wb_bus   = {gr_we, dest, final_result, pc};

  assign mem_fwd_we      = mem_valid_q && gr_we;
  assign mem_fwd_dest    = dest;
  assign mem_fwd_data    = final_result;
  assign mem_fwd_is_load = mem_valid_q && res_from_mem;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_to_mem_valid;
  logic [73:0] exe_to_mem_bus;
  logic        mem_allow_in;
  logic [31:0] data_sram_rdata;
  logic        wb_allow_in;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_dest;
  logic [31:0] mem_fwd_data;
  logic        mem_fwd_is_load;

  int total = 0;
  int bad   = 0;

  logic [69:0] sb_q[$];

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_to_mem_bus   (exe_to_mem_bus),
    .mem_allow_in     (mem_allow_in),
    .data_sram_rdata  (data_sram_rdata),
    .wb_allow_in      (wb_allow_in),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_fwd_we       (mem_fwd_we),
    .mem_fwd_dest     (mem_fwd_dest),
    .mem_fwd_data     (mem_fwd_data),
    .mem_fwd_is_load  (mem_fwd_is_load)
  );

  always #5 clk = ~clk;

  // Reference model of the load formatter: shift the addressed lane down, then extend.
  function automatic logic [31:0] model(input logic rfm, input logic [2:0] op,
                                        input logic [31:0] alu, input logic [31:0] rd);
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    b_sh = rd >> (alu[1:0] * 8);
    h_sh = rd >> (alu[1] ? 16 : 0);
    if (!rfm) return alu;
    if (op == 3'd1) return 32'(signed'(b_sh[7:0]));
    if (op == 3'd2) return 32'(signed'(h_sh[15:0]));
    if (op == 3'd3) return b_sh & 32'h0000_00FF;
    if (op == 3'd4) return h_sh & 32'h0000_FFFF;
    return rd;
  endfunction

  function automatic logic [73:0] mk(input logic rfm, input logic [2:0] op, input logic we,
                                     input logic [4:0] dst, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {rfm, op, we, dst, alu, pc};
  endfunction

  task automatic push(input logic rfm, input logic [2:0] op, input logic we,
                      input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] pc,
                      input logic [31:0] rd);
    sb_q.push_back({we, dst, model(rfm, op, alu, rd), pc});
  endtask

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic ev, input logic [73:0] eb, input logic [31:0] rd,
                        input logic wa);
    exe_to_mem_valid = ev;
    exe_to_mem_bus   = eb;
    data_sram_rdata  = rd;
    wb_allow_in      = wa;
    #1;
  endtask

  // Scoreboard check on the WB handshake, then advance one clock.
  task automatic tick();
    logic [69:0] exp;
    if (mem_to_wb_valid === 1'b1 && wb_allow_in === 1'b1) begin
      total++;
      assert (sb_q.size() != 0)
      else begin
        bad++;
        $error("FAIL sb_unexpected observed=%h expected=none", mem_to_wb_bus);
      end
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        chk("wb_bus", mem_to_wb_bus, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  t_op  [4] = '{3'd3, 3'd5, 3'd2, 3'd1};
  logic [31:0] t_alu [4] = '{32'h3, 32'h1, 32'h1, 32'h2};
  logic [31:0] t_rd  [4] = '{32'h8011_2233, 32'h89AB_CDEF, 32'h0000_8001, 32'h007F_0000};
  logic [31:0] t_exp [4] = '{32'h0000_0080, 32'h89AB_CDEF, 32'hFFFF_8001, 32'h0000_007F};
  logic [31:0] t_pc  [4] = '{32'h300, 32'h304, 32'h308, 32'h30C};

  logic [73:0] stall_bus;

  initial begin
    reset            = 1'b1;
    exe_to_mem_valid = 1'b0;
    exe_to_mem_bus   = '0;
    data_sram_rdata  = '0;
    wb_allow_in      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    set_in(1'b0, '0, 32'h0, 1'b1);
    chk("rst_allow_in", 70'(mem_allow_in), 70'd1);
    chk("rst_valid", 70'(mem_to_wb_valid), 70'd0);
    chk("rst_bus", mem_to_wb_bus, 70'd0);
    chk("rst_fwd_we", 70'(mem_fwd_we), 70'd0);
    chk("rst_fwd_is_load", 70'(mem_fwd_is_load), 70'd0);
    chk("rst_fwd_dest_data", 70'({mem_fwd_dest, mem_fwd_data}), 70'd0);

    // ld.b, byte 1 of 0x123480FF is 0x80
    set_in(1'b1, mk(1'b1, 3'd1, 1'b1, 5'd3, 32'h1001, 32'h100), 32'h0, 1'b1);
    push(1'b1, 3'd1, 1'b1, 5'd3, 32'h1001, 32'h100, 32'h1234_80FF);
    tick();
    set_in(1'b0, '0, 32'h1234_80FF, 1'b1);
    chk("ldb_valid", 70'(mem_to_wb_valid), 70'd1);
    chk("ldb_data", 70'(mem_fwd_data), 70'h0_FFFF_FF80);
    chk("ldb_is_load", 70'(mem_fwd_is_load), 70'd1);
    tick();
    // Stage empty but payload still holds a load: enables must be low
    chk("empty_is_load", 70'(mem_fwd_is_load), 70'd0);
    chk("empty_fwd_we", 70'(mem_fwd_we), 70'd0);

    // ld.hu followed back-to-back by ld.h on the same address
    set_in(1'b1, mk(1'b1, 3'd4, 1'b1, 5'd4, 32'h2002, 32'h104), 32'h0, 1'b1);
    push(1'b1, 3'd4, 1'b1, 5'd4, 32'h2002, 32'h104, 32'hBEEF_1234);
    tick();
    set_in(1'b1, mk(1'b1, 3'd2, 1'b1, 5'd4, 32'h2002, 32'h108), 32'hBEEF_1234, 1'b1);
    push(1'b1, 3'd2, 1'b1, 5'd4, 32'h2002, 32'h108, 32'hBEEF_1234);
    chk("ldhu_data", 70'(mem_fwd_data), 70'h0_0000_BEEF);
    tick();
    set_in(1'b0, '0, 32'hBEEF_1234, 1'b1);
    chk("ldh_data", 70'(mem_fwd_data), 70'h0_FFFF_BEEF);
    tick();

    // Non-load
    set_in(1'b1, mk(1'b0, 3'd0, 1'b1, 5'd5, 32'hCAFE_F00D, 32'h10C), 32'h0, 1'b1);
    push(1'b0, 3'd0, 1'b1, 5'd5, 32'hCAFE_F00D, 32'h10C, 32'hDEAD_BEEF);
    tick();
    set_in(1'b0, '0, 32'hDEAD_BEEF, 1'b1);
    chk("alu_bus", mem_to_wb_bus, {1'b1, 5'd5, 32'hCAFE_F00D, 32'h10C});
    chk("alu_fwd_we", 70'(mem_fwd_we), 70'd1);
    chk("alu_fwd_dest", 70'(mem_fwd_dest), 70'd5);
    chk("alu_is_load", 70'(mem_fwd_is_load), 70'd0);
    tick();

    // Stall: ld.w held for 3 cycles while SRAM data goes away
    set_in(1'b1, mk(1'b1, 3'd0, 1'b1, 5'd7, 32'h3000, 32'h110), 32'h0, 1'b1);
    push(1'b1, 3'd0, 1'b1, 5'd7, 32'h3000, 32'h110, 32'hA5A5_A5A5);
    tick();
    stall_bus = mk(1'b0, 3'd0, 1'b1, 5'd8, 32'h55, 32'h114);
    set_in(1'b1, stall_bus, 32'hA5A5_A5A5, 1'b0);
    chk("stall_allow_in0", 70'(mem_allow_in), 70'd0);
    chk("stall_data0", 70'(mem_fwd_data), 70'h0_A5A5_A5A5);
    tick();
    for (int i = 1; i < 3; i++) begin
      set_in(1'b1, stall_bus, 32'h0, 1'b0);
      chk($sformatf("stall_allow_in%0d", i), 70'(mem_allow_in), 70'd0);
      chk($sformatf("stall_data%0d", i), 70'(mem_fwd_data), 70'h0_A5A5_A5A5);
      chk($sformatf("stall_pc%0d", i), 70'(mem_to_wb_bus[31:0]), 70'h110);
      tick();
    end
    set_in(1'b1, stall_bus, 32'h0, 1'b1);
    chk("release_allow_in", 70'(mem_allow_in), 70'd1);
    chk("release_data", 70'(mem_fwd_data), 70'h0_A5A5_A5A5);
    push(1'b0, 3'd0, 1'b1, 5'd8, 32'h55, 32'h114, 32'h0);
    tick();
    set_in(1'b0, '0, 32'h0, 1'b1);
    chk("after_stall_pc", 70'(mem_to_wb_bus[31:0]), 70'h114);
    tick();
    set_in(1'b0, '0, 32'h0, 1'b1);
    chk("idle_valid", 70'(mem_to_wb_valid), 70'd0);

    // Back-to-back: four loads, one per cycle, assorted widths and lanes
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        set_in(1'b1, mk(1'b1, t_op[i], 1'b1, 5'(i + 1), t_alu[i], t_pc[i]),
               (i > 0) ? t_rd[i-1] : 32'h0, 1'b1);
        push(1'b1, t_op[i], 1'b1, 5'(i + 1), t_alu[i], t_pc[i], t_rd[i]);
      end else begin
        set_in(1'b0, '0, t_rd[3], 1'b1);
      end
      if (i > 0) begin
        chk($sformatf("b2b_valid%0d", i), 70'(mem_to_wb_valid), 70'd1);
        chk($sformatf("b2b_data%0d", i), 70'(mem_fwd_data), 70'(t_exp[i-1]));
        chk($sformatf("b2b_pc%0d", i), 70'(mem_to_wb_bus[31:0]), 70'(t_pc[i-1]));
      end
      tick();
    end

    // Reset during a stall discards the held instruction
    set_in(1'b1, mk(1'b1, 3'd0, 1'b1, 5'd9, 32'h400, 32'h200), 32'h0, 1'b1);
    push(1'b1, 3'd0, 1'b1, 5'd9, 32'h400, 32'h200, 32'h1111_1111);
    tick();
    set_in(1'b1, mk(1'b0, 3'd0, 1'b1, 5'd10, 32'h66, 32'h204), 32'h1111_1111, 1'b0);
    chk("pre_rst_valid", 70'(mem_to_wb_valid), 70'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    set_in(1'b0, '0, 32'h2222_2222, 1'b1);
    chk("midrst_valid", 70'(mem_to_wb_valid), 70'd0);
    chk("midrst_allow_in", 70'(mem_allow_in), 70'd1);
    chk("midrst_fwd_we", 70'(mem_fwd_we), 70'd0);
    chk("midrst_bus", mem_to_wb_bus, 70'd0);
    tick();
    tick();
    chk("sb_drained", 70'(sb_q.size()), 70'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 exe_to_mem_valid  input  1  EX holds a valid instruction for MEM.
REQ-005 exe_to_mem_bus  input  74  {res_from_mem[73], load_op[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-006 mem_allow_in  output  1  MEM can accept a new instruction this cycle.
REQ-007 data_sram_rdata  input  32  load data returned by data SRAM, one cycle after EX issued the request.
REQ-008 wb_allow_in  input  1  WB can accept an instruction this cycle.
REQ-009 mem_to_wb_valid  output  1  MEM presents a valid instruction to WB.
REQ-010 mem_to_wb_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-011 mem_fwd_we  output  1  mem_valid AND gr_we, for ID bypass and hazard logic.
REQ-012 mem_fwd_dest  output  5  destination register of the held instruction.
REQ-013 mem_fwd_data  output  32  final_result of the held instruction.
REQ-014 mem_fwd_is_load  output  1  mem_valid AND res_from_mem, for load-use detection in ID.

Function
REQ-015 State: mem_valid (1 bit), 74-bit payload register, 32-bit rdata hold register, 1-bit hold_valid flag.
REQ-016 mem_ready_go SHALL be constant 1.
REQ-017 mem_allow_in = !mem_valid OR (mem_ready_go AND wb_allow_in).
REQ-018 mem_to_wb_valid = mem_valid AND mem_ready_go.
REQ-019 When mem_allow_in=1, mem_valid SHALL load exe_to_mem_valid on the next edge.
REQ-020 The payload register SHALL load exe_to_mem_bus only when mem_allow_in AND exe_to_mem_valid; otherwise it SHALL hold.
REQ-021 On the first cycle an instruction occupies MEM, data_sram_rdata is valid; the block SHALL capture it into the hold register and set hold_valid at the end of that cycle.
REQ-022 hold_valid SHALL clear whenever a new instruction is loaded (REQ-020) or mem_valid becomes 0.
REQ-023 Effective load data = hold register if hold_valid, else data_sram_rdata, so stalls of any length leave the result stable.
REQ-024 Byte select: alu_result[1:0] 00/01/10/11 -> rdata bits [7:0]/[15:8]/[23:16]/[31:24].
REQ-025 Half select: alu_result[1]=0 -> [15:0], 1 -> [31:16]; alu_result[0] is ignored, and the block SHALL raise no misalignment exception.
REQ-026 load_op: 000 = ld.w (full word), 001 = ld.b (sign-extended), 010 = ld.h (sign-extended), 011 = ld.bu (zero-extended), 100 = ld.hu (zero-extended); codes 101-111 SHALL behave as ld.w.
REQ-027 final_result = loaded value if res_from_mem, else alu_result.
REQ-028 mem_to_wb_bus fields gr_we, dest and pc SHALL pass through from the payload; the output SHALL be purely combinational from the registered state and data_sram_rdata.
REQ-029 A simultaneous drain to WB and load from EX SHALL produce back-to-back issue with no bubble.
REQ-030 When mem_valid=0, all mem_fwd_* enables SHALL be 0 regardless of the payload contents.

Reset
REQ-031 While reset=1 the following SHALL be cleared on the next edge: mem_valid, hold_valid, the payload register and the hold register (all to 0).
REQ-032 Post-reset outputs: mem_allow_in=1, mem_to_wb_valid=0, mem_to_wb_bus=0, all mem_fwd_* = 0.
REQ-033 Reset asserted mid-stall SHALL discard the held instruction; no write to WB occurs afterwards.

Verification
REQ-034 ld.b: alu_result=0x1001, rdata=0x123480FF -> final_result 0xFFFFFF80 and mem_to_wb_valid=1 one cycle after entry.
REQ-035 ld.hu and ld.h: alu_result=0x2002, rdata=0xBEEF1234 -> ld.hu gives 0x0000BEEF, ld.h gives 0xFFFFBEEF.
REQ-036 Non-load: res_from_mem=0, alu_result=0xCAFEF00D, gr_we=1, dest=5 -> bus {1, 5, 0xCAFEF00D, pc}, mem_fwd_we=1, mem_fwd_dest=5.
REQ-037 Stall: ld.w enters with rdata=0xA5A5A5A5, wb_allow_in=0 for 3 cycles while rdata changes to 0x0 -> final_result stays 0xA5A5A5A5, mem_allow_in=0 throughout, and EX payload is not taken.
REQ-038 Back-to-back: 4 consecutive valid instructions with wb_allow_in=1 -> 4 consecutive cycles of mem_to_wb_valid=1 with pcs in order.
REQ-039 Reset during stall: reset=1 for one cycle -> mem_to_wb_valid=0, mem_allow_in=1, mem_fwd_we=0, and the bus is zero on the next cycle.
